// File: rtl/ysyx_core_sequencer_pkg.sv
// Shared types for the NPC sequencer: FSM state encodings, halt reasons and reset PC.
package ysyx_core_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_EXEC       = 3'd2,
    S_WB         = 3'd3,
    S_HALT       = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    HALT_NONE     = 3'd0,
    HALT_EBREAK   = 3'd1,
    HALT_ILLEGAL  = 3'd2,
    HALT_TIMEOUT  = 3'd3,
    HALT_MISALIGN = 3'd4
  } halt_code_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_core_sequencer_if.sv
// Instruction-fetch handshake between the sequencer (master) and the IFU (slave).
interface ysyx_core_sequencer_if;

  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        ifu_rsp_ready;

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst
  );

endinterface

// File: rtl/ysyx_core_sequencer_perf_cnt.sv
// Cycle and retired-instruction counters; cycle counting stops while frozen (halted core).
module ysyx_core_sequencer_perf_cnt #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = freeze ? cycle_q : cycle_q + CNT_W'(1);
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt = cycle_q;
  assign instret   = instret_q;

endmodule

// File: rtl/ysyx_core_sequencer.sv
// Multi-cycle NPC control FSM: fetch over the IFU handshake, execute, write back, halt.
// Holds IR and PC; strobes are forced low while reset is asserted.
module ysyx_core_sequencer
  import ysyx_core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int          CNT_W         = 64,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_core_sequencer_if.master ifu,
  output logic [31:0]           inst,
  input  logic                  dec_rf_wr_en,
  input  logic                  dec_is_ebreak,
  input  logic                  dec_illegal,
  input  logic [31:0]           exu_next_pc,
  output logic                  rf_wr_en,
  output logic                  ebreak_trig,
  output logic [31:0]           pc,
  output logic                  halted,
  output logic [2:0]            halt_code,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instret,
  output logic [2:0]            state_dbg
);

  localparam bit         TMO_EN    = (FETCH_TIMEOUT != 0);
  localparam logic [7:0] TMO_LIMIT = 8'(FETCH_TIMEOUT - 1);

  state_e      state_q, state_d;
  halt_code_e  halt_code_q, halt_code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [7:0]  tmo_q, tmo_d;

  logic req_valid, rsp_ready, wr_en, ebreak, retire;

  always_comb begin
    state_d     = state_q;
    halt_code_d = halt_code_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    tmo_d       = tmo_q;
    req_valid   = 1'b0;
    rsp_ready   = 1'b0;
    wr_en       = 1'b0;
    ebreak      = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      S_FETCH_REQ: begin
        req_valid = 1'b1;
        if (ifu.ifu_req_ready) begin
          state_d = S_FETCH_WAIT;
          tmo_d   = '0;
        end
      end
      // tmo_q counts response-less WAIT cycles; the FETCH_TIMEOUT-th one halts
      S_FETCH_WAIT: begin
        rsp_ready = 1'b1;
        if (ifu.ifu_rsp_valid) begin
          inst_d  = ifu.ifu_rsp_inst;
          state_d = S_EXEC;
        end else if (TMO_EN && (tmo_q == TMO_LIMIT)) begin
          state_d     = S_HALT;
          halt_code_d = HALT_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (dec_illegal) begin
          state_d     = S_HALT;
          halt_code_d = HALT_ILLEGAL;
        end else if (dec_is_ebreak) begin
          ebreak      = 1'b1;
          retire      = 1'b1;
          state_d     = S_HALT;
          halt_code_d = HALT_EBREAK;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (exu_next_pc[1:0] != 2'b00) begin
          state_d     = S_HALT;
          halt_code_d = HALT_MISALIGN;
        end else begin
          wr_en   = dec_rf_wr_en;
          pc_d    = exu_next_pc;
          retire  = 1'b1;
          state_d = S_FETCH_REQ;
        end
      end
      S_HALT: begin
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH_REQ;
      halt_code_q <= HALT_NONE;
      pc_q        <= RESET_PC;
      inst_q      <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      halt_code_q <= halt_code_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      tmo_q       <= tmo_d;
    end
  end

  ysyx_core_sequencer_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .freeze    (state_q == S_HALT),
    .retire    (retire),
    .cycle_cnt (cycle_cnt),
    .instret   (instret)
  );

  assign ifu.ifu_req_valid = rst_n & req_valid;
  assign ifu.ifu_req_addr  = pc_q;
  assign ifu.ifu_rsp_ready = rst_n & rsp_ready;
  assign rf_wr_en          = rst_n & wr_en;
  assign ebreak_trig       = rst_n & ebreak;
  assign inst              = inst_q;
  assign pc                = pc_q;
  assign halted            = (state_q == S_HALT);
  assign halt_code         = halt_code_q;
  assign state_dbg         = state_q;

endmodule
